// File: rtl/prescaled_mod_counter.sv
// Parametrised up/down modulo counter with prescaler, parallel load,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module prescaled_mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned     PRESCALE = 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // Top count held in WIDTH bits, so MODULUS = 2**WIDTH never needs a wider adder.
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 64'd1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             event_hit;

  always_comb begin
    q_d       = q_q;
    pre_d     = pre_q;
    step      = 1'b0;
    event_hit = 1'b0;
    if (clr) begin
      q_d   = '0;
      pre_d = '0;
    end else if (load) begin
      q_d   = (load_val > MAX_Q) ? MAX_Q : load_val;
      pre_d = '0;
    end else if (en) begin
      step  = (pre_q == PRE_LAST);
      pre_d = step ? '0 : pre_q + PW'(1);
      if (step) begin
        if (up) begin
          if (q_q < MAX_Q) begin
            q_d = q_q + WIDTH'(1);
          end else begin
            event_hit = 1'b1;
            q_d       = SATURATE ? MAX_Q : '0;
          end
        end else begin
          if (q_q != '0) begin
            q_d = q_q - WIDTH'(1);
          end else begin
            event_hit = 1'b1;
            q_d       = SATURATE ? '0 : MAX_Q;
          end
        end
      end
    end
    tc_d  = event_hit;
    // A boundary event on the same edge beats ovf_clr.
    ovf_d = event_hit ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: doc/prescaled_mod_counter.md
# prescaled_mod_counter

Parametrised synchronous up/down counter. It replaces the fixed 4-bit ripple counter wherever a configurable-width, configurable-modulus count is needed (timers, divider chains, event counters). It adds:
- a programmable prescaler
- parallel load
- wrap or saturate mode
- a terminal-count pulse and a sticky overflow flag

All state changes on the rising edge of one clock, except reset.

## Interface
- WIDTH, 8: counter width in bits, 2..32.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- PRESCALE, 1: enabled cycles per count step, 1..256.
- SATURATE, 0: 0 = wrap at the boundary, 1 = hold at the boundary.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of the count and prescaler.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- en  in  1  count enable; feeds the prescaler.
- up  in  1  direction: 1 = up, 0 = down; sampled on step cycles only.
- ovf_clr  in  1  synchronous clear of ovf.
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky boundary-event flag, registered.

## Operation
- **Reset (asynchronous):** reset=1 forces q=0, tc=0, ovf=0 and prescaler pre_cnt=0 immediately, independent of clk. The block holds these values while reset is high.
- **Priority per edge:** reset > clr > load > step. tc defaults to 0 every edge unless a boundary event occurs.
- **clr:** q←0, pre_cnt←0, tc←0. ovf is unaffected.
- **load:** q←min(load_val, MODULUS-1), pre_cnt←0, tc←0. load overrides en in the same cycle.
- **Prescaler:** with en=1 and no clr/load:
  - if pre_cnt==PRESCALE-1, this is a step cycle and pre_cnt←0;
  - otherwise pre_cnt←pre_cnt+1.
  - With en=0, pre_cnt and q hold.
  - PRESCALE=1 makes every enabled cycle a step cycle.
- **Step, up=1:**
  - if q<MODULUS-1, q←q+1;
  - otherwise this is a boundary event: q←0 (SATURATE=0) or q holds at MODULUS-1 (SATURATE=1).
- **Step, up=0:**
  - if q>0, q←q-1;
  - otherwise this is a boundary event: q←MODULUS-1 (SATURATE=0) or q holds at 0 (SATURATE=1).
- **Boundary event:** tc←1 for that edge only, and ovf←1.
  - In saturate mode, every step attempted at the boundary is an event.
- **ovf_clr:** ovf←0, unless a boundary event occurs on the same edge, in which case ovf stays 1 (set wins).
- **Arithmetic:** the next-count computation must not overflow WIDTH bits when MODULUS=2**WIDTH. The boundary compare uses MODULUS-1 held in WIDTH bits.

## Timing
- q, tc and ovf are all registered, with no combinational input-to-output paths.
- Step latency: q reflects a step on the same rising edge that ends the step cycle.
- tc is high during exactly the one cycle following a boundary-event edge, coincident with q showing the wrapped or held value.
- Back-to-back events at PRESCALE=1 in saturate mode give tc high continuously, one pulse per edge.
- Prescaler phase:
  - after reset, clr or load, the first step occurs on the PRESCALE-th consecutive enabled edge;
  - gaps in en stretch this count but do not reset it.
- Direction changes between step cycles take effect only on the next step cycle.
- Reset asserted mid-count clears everything at once. After deassertion, the first edge with en=1 is enabled cycle 1 of the prescaler.

## Test plan
- **Up wrap.** WIDTH=4, MODULUS=10, PRESCALE=1, SATURATE=0. Reset, then en=1, up=1 for 12 cycles → q=1..9,0,1,2. tc=1 only in the cycle where q=0. ovf=1 from then on.
- **Down wrap and ovf.** Same parameters, q=0, up=0, 1 step → q=9, tc pulse. Then ovf_clr=1 with no event → ovf=0. Then ovf_clr=1 on a wrap edge → ovf stays 1.
- **Saturate.** SATURATE=1, MODULUS=10. Load 8, up=1, 4 steps → q=9,9,9,9 with tc high for the last 3 cycles. Then up=0, 10 steps → q ends 0 and stays 0, tc high on each subsequent attempt.
- **Prescale.** PRESCALE=3. en=1 for 9 cycles → q increments at edges 3, 6, 9 only. en low for 2 cycles mid-way → step delayed by 2 cycles, q unchanged during the gap.
- **Load/clear priority.** load_val=12 with MODULUS=10 → q=9. load=1 and en=1 on a step cycle → q=load value, no step. clr=1 and load=1 together → q=0. clr with ovf=1 → ovf remains 1.
- **Async reset.** Assert reset between clock edges at q=7, pre_cnt=2 → q=0, tc=0, ovf=0 before the next edge. After deassertion, the first step occurs PRESCALE enabled edges later.
